// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared definitions for the constant-checking UART receiver:
//   receiver state encoding, the shared test constant and its parts,
//   the statistics counter width and a saturating-increment helper.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } rx_state_t;

   localparam int MY_CONSTANT1      = 10;
   localparam int MY_CONSTANT2      = 20;
   localparam int MY_OTHER_CONSTANT = MY_CONSTANT1 + MY_CONSTANT2 + 7;

   localparam int COUNT_W = 16;

   // Counters stick at all-ones instead of wrapping back to zero.
   function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
      return (v == '1) ? v : v + COUNT_W'(1);
   endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer
//   Loadable down-counter used for both the half-bit and full-bit waits.
//   Ports:
//     i_clock     system clock
//     i_reset     synchronous active-high reset (count -> 0)
//     i_load      load strobe; takes priority over counting
//     i_load_val  value loaded on i_load
//     o_tick      high while the count is zero
module uart_bit_timer #(
   parameter int TIMER_W = 2
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic               i_load,
   input  logic [TIMER_W-1:0] i_load_val,
   output logic               o_tick
);

   logic [TIMER_W-1:0] r_count;

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (r_count != '0) begin
         r_count <= r_count - TIMER_W'(1);
      end
   end

   assign o_tick = (r_count == '0);

endmodule

// File: rtl/uart_const_rx.sv
// uart_const_rx
//   8N1 serial receiver that checks every good byte against EXPECTED and
//   keeps saturating counts of matches and framing errors.
//   Ports:
//     clock        system clock, rising edge
//     reset        synchronous active-high reset
//     ser_in       serial line, idles high
//     rx_valid     one-cycle pulse per byte with a good stop bit
//     rx_data      last good byte, held between pulses
//     rx_match     rx_data == EXPECTED, only while rx_valid is high
//     busy         receiver is inside a frame (any state but IDLE)
//     match_count  saturating count of matching good bytes
//     error_count  saturating count of framing errors
module uart_const_rx
   import uart_pkg::*;
#(
   parameter int         CLOCKS_PER_BIT = 4,
   parameter logic [7:0] EXPECTED       = 8'(MY_OTHER_CONSTANT)
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               ser_in,
   output logic               rx_valid,
   output logic [7:0]         rx_data,
   output logic               rx_match,
   output logic               busy,
   output logic [COUNT_W-1:0] match_count,
   output logic [COUNT_W-1:0] error_count
);

   localparam int TIMER_W = (CLOCKS_PER_BIT > 2) ? $clog2(CLOCKS_PER_BIT) : 1;
   localparam int HALF    = (CLOCKS_PER_BIT - 1) / 2;
   localparam logic [TIMER_W-1:0] FULL_LOAD = TIMER_W'(CLOCKS_PER_BIT - 1);
   // The IDLE edge that spots the start bit is already the first cycle of
   // the half-bit wait, so START is loaded one short of the half-bit count.
   localparam logic [TIMER_W-1:0] HALF_LOAD = TIMER_W'((HALF > 0) ? HALF - 1 : 0);

   rx_state_t          r_state;
   logic               r_ser_q;
   logic [2:0]         r_bit_idx;
   logic [7:0]         r_shift;
   logic               r_rx_valid;
   logic [7:0]         r_rx_data;
   logic               r_rx_match;
   logic               r_busy;
   logic [COUNT_W-1:0] r_match_count;
   logic [COUNT_W-1:0] r_error_count;

   logic               w_tick;
   logic               w_load;
   logic [TIMER_W-1:0] w_load_val;

   uart_bit_timer #(.TIMER_W(TIMER_W)) u_timer (
      .i_clock    (clock),
      .i_reset    (reset),
      .i_load     (w_load),
      .i_load_val (w_load_val),
      .o_tick     (w_tick)
   );

   // Half-bit wait on start detection, full-bit reload after every sample
   // that leads into another bit (start -> data, data -> data/stop).
   always_comb begin
      w_load     = 1'b0;
      w_load_val = FULL_LOAD;
      case (r_state)
         IDLE: begin
            if (!r_ser_q) begin
               w_load     = 1'b1;
               w_load_val = HALF_LOAD;
            end
         end
         START, DATA: w_load = w_tick;
         default: w_load = 1'b0;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_ser_q       <= 1'b1;
         r_state       <= IDLE;
         r_bit_idx     <= '0;
         r_shift       <= '0;
         r_rx_valid    <= 1'b0;
         r_rx_data     <= '0;
         r_rx_match    <= 1'b0;
         r_busy        <= 1'b0;
         r_match_count <= '0;
         r_error_count <= '0;
      end else begin
         r_ser_q    <= ser_in;
         r_rx_valid <= 1'b0;
         r_rx_match <= 1'b0;
         case (r_state)
            IDLE: begin
               if (!r_ser_q) begin
                  r_state <= START;
                  r_busy  <= 1'b1;
               end
            end
            START: begin
               if (w_tick) begin
                  if (!r_ser_q) begin
                     r_state   <= DATA;
                     r_bit_idx <= '0;
                  end else begin
                     // Line went back high before mid-bit: false start.
                     r_state <= IDLE;
                     r_busy  <= 1'b0;
                  end
               end
            end
            DATA: begin
               if (w_tick) begin
                  // LSB first: after eight shifts the first bit sits in bit 0.
                  r_shift   <= {r_ser_q, r_shift[7:1]};
                  r_bit_idx <= r_bit_idx + 3'd1;
                  if (r_bit_idx == 3'd7) begin
                     r_state <= STOP;
                  end
               end
            end
            STOP: begin
               if (w_tick) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
                  if (r_ser_q) begin
                     r_rx_valid <= 1'b1;
                     r_rx_data  <= r_shift;
                     r_rx_match <= (r_shift == EXPECTED);
                     if (r_shift == EXPECTED) begin
                        r_match_count <= sat_inc(r_match_count);
                     end
                  end else begin
                     r_error_count <= sat_inc(r_error_count);
                  end
               end
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign rx_valid    = r_rx_valid;
   assign rx_data     = r_rx_data;
   assign rx_match    = r_rx_match;
   assign busy        = r_busy;
   assign match_count = r_match_count;
   assign error_count = r_error_count;

endmodule
